// File: rtl/lfsr_code_gen.sv
// XNOR Fibonacci LFSR with seed load, lock-up protection and a Mastermind code-draw engine.
// Optional macro LFSR_CODE_NO_REPEAT_EN makes every drawn code use distinct colours.
module lfsr_code_gen #(
    parameter int                 WIDTH    = 10,
    parameter logic [WIDTH-1:0]   TAP_MASK = 10'h240,
    parameter int                 DIGITS   = 4,
    parameter int                 COLORS   = 6,
    parameter int                 DIGIT_W  = 3
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        enable,
    input  logic                        load,
    input  logic [WIDTH-1:0]            seed,
    input  logic                        start,
    input  logic                        ack,
    output logic                        busy,
    output logic                        code_valid,
    output logic [DIGITS*DIGIT_W-1:0]   code,
    output logic [WIDTH-1:0]            lfsr_out
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [DIGIT_W:0] COLORS_LIM = (DIGIT_W + 1)'(COLORS);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   lfsr;
    logic [WIDTH-1:0]   lfsr_next;
    logic [CNT_W-1:0]   count;
    logic [DIGIT_W-1:0] cand;
    logic               in_range;
    logic               dup;
    logic               accept;

    if (WIDTH < 3) begin : g_bad_width
        $error("lfsr_code_gen: WIDTH must be at least 3");
    end
    if (DIGIT_W > WIDTH) begin : g_bad_digit_w
        $error("lfsr_code_gen: DIGIT_W must not exceed WIDTH");
    end
    if (COLORS < 2 || COLORS > (1 << DIGIT_W)) begin : g_bad_colors
        $error("lfsr_code_gen: COLORS must be in 2..2**DIGIT_W");
    end

    assign lfsr_out = lfsr;

    always_comb begin
        lfsr_next = {lfsr[WIDTH-2:0], ~^(lfsr & TAP_MASK)};
        cand      = lfsr[DIGIT_W-1:0];
        in_range  = {1'b0, cand} < COLORS_LIM;
        accept    = in_range && !dup;
    end

`ifdef LFSR_CODE_NO_REPEAT_EN
    if (COLORS < DIGITS) begin : g_bad_no_repeat
        $error("lfsr_code_gen: distinct-colour codes need COLORS >= DIGITS");
    end

    // Only digits already written in this draw (index below count) can clash.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (CNT_W'(i) < count && code[i*DIGIT_W +: DIGIT_W] == cand) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    // All-ones is the XNOR lock-up state, so a seed of all-ones is mapped to zero.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= (seed == '1) ? '0 : seed;
        end else if (state == DRAW || enable) begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            code       <= '0;
            count      <= '0;
            busy       <= 1'b0;
            code_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= DRAW;
                        code  <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (count == CNT_W'(i)) begin
                                code[i*DIGIT_W +: DIGIT_W] <= cand;
                            end
                        end
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(DIGITS - 1)) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            code_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        state      <= IDLE;
                        code_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    code_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_code_gen.sv
// Scoreboard bench for lfsr_code_gen: directed LFSR/draw vectors plus a 4-colour instance.
// Expected codes go into a queue; a negedge monitor pops one whenever code_valid rises.
module tb_lfsr_code_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, load, start, ack;
    logic [9:0]  seed;
    logic        busy, code_valid;
    logic [11:0] code;
    logic [9:0]  lfsr_out;

    logic        enable2, load2, start2, ack2;
    logic [9:0]  seed2;
    logic        busy2, valid2;
    logic [11:0] code2;
    logic [9:0]  lfsr2;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] expq[$];
    logic        last_valid = 1'b0;

    always #5 clk = ~clk;

    lfsr_code_gen dut (
        .clk(clk), .Reset(reset), .enable(enable), .load(load), .seed(seed),
        .start(start), .ack(ack), .busy(busy), .code_valid(code_valid),
        .code(code), .lfsr_out(lfsr_out)
    );

    lfsr_code_gen #(.COLORS(4), .DIGITS(4)) dut2 (
        .clk(clk), .Reset(reset), .enable(enable2), .load(load2), .seed(seed2),
        .start(start2), .ack(ack2), .busy(busy2), .code_valid(valid2),
        .code(code2), .lfsr_out(lfsr2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [9:0] sd,
                                 input logic st, input logic ak);
        enable = en;
        load   = ld;
        seed   = sd;
        start  = st;
        ack    = ak;
        tick();
    endtask

    // Starts a default draw from state 0 and checks the 10-cycle latency.
    task automatic default_draw();
        expq.push_back(12'h8C8);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        start = 1'b0;
        checkOutput("busy after start", 32'(busy), 1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkOutput("drawing flags", 32'({busy, code_valid}), 'b10);
        end
        tick();
        checkOutput("done flags", 32'({busy, code_valid}), 'b01);
        checkOutput("lfsr after draw", 32'(lfsr_out), 'h3F8);
    endtask

    always @(negedge clk) begin
        if (code_valid && !last_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected code: got 0x%0h, expected none", code);
            end else begin
                checkOutput("scoreboard code", 32'(code), 32'(expq.pop_front()));
            end
        end
        last_valid = code_valid;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic [7:0]  seen;
        logic        bad, rep, any_rep;
        logic [2:0]  dig;

        reset = 1'b1; enable = 1'b0; load = 1'b0; seed = '0; start = 1'b0; ack = 1'b0;
        enable2 = 1'b0; load2 = 1'b0; seed2 = '0; start2 = 1'b0; ack2 = 1'b0;
        any_rep = 1'b0;
        tick();
        tick();
        checkOutput("reset lfsr", 32'(lfsr_out), 0);
        checkOutput("reset code", 32'(code), 0);
        checkOutput("reset flags", 32'({busy, code_valid}), 0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
        checkOutput("step 1", 32'(lfsr_out), 'h001);
        tick();
        checkOutput("step 2", 32'(lfsr_out), 'h003);
        tick();
        checkOutput("step 3", 32'(lfsr_out), 'h007);
        #2 reset = 1'b1;
        #1 checkOutput("async reset", 32'(lfsr_out), 0);
        reset = 1'b0;
        enable = 1'b0;

        applyStimulus(1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0);
        checkOutput("load all-ones", 32'(lfsr_out), 0);
        applyStimulus(1'b0, 1'b1, 10'h155, 1'b0, 1'b0);
        checkOutput("load seed", 32'(lfsr_out), 'h155);
        applyStimulus(1'b1, 1'b1, 10'h155, 1'b0, 1'b0);
        checkOutput("load beats enable", 32'(lfsr_out), 'h155);
        load = 1'b0;
        enable = 1'b0;

        reset = 1'b1;
        #1 reset = 1'b0;
        default_draw();

        // DONE must hold the code and ignore start until ack arrives.
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("hold code", 32'(code), 'h8C8);
            checkOutput("hold valid", 32'(code_valid), 1);
        end
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        ack = 1'b0;
        checkOutput("valid after ack", 32'(code_valid), 0);
        checkOutput("code after ack", 32'(code), 'h8C8);
        tick();
        checkOutput("idle after ack", 32'(busy), 0);

        reset = 1'b1;
        #1 reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        tick();
        checkOutput("partial code", 32'(code), 'h008);
        reset = 1'b1;
        #1;
        checkOutput("mid-draw reset flags", 32'({busy, code_valid}), 0);
        checkOutput("mid-draw reset code", 32'(code), 0);
        checkOutput("mid-draw reset lfsr", 32'(lfsr_out), 0);
        reset = 1'b0;
        default_draw();
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        ack = 1'b0;

        // Load on the first draw cycle: digit 0 comes from the old state, the rest from 0x1FC.
        reset = 1'b1;
        #1 reset = 1'b0;
`ifdef LFSR_CODE_NO_REPEAT_EN
        expq.push_back(12'h660);
`else
        expq.push_back(12'h220);
`endif
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 10'h1FC, 1'b0, 1'b0);
        load = 1'b0;
        n = 0;
        while (!code_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("load-draw completes", 32'(code_valid), 1);
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        ack = 1'b0;

        for (int d = 0; d < 20; d++) begin
            seed2 = 10'($urandom_range(0, 1022));
            load2 = 1'b1;
            tick();
            load2 = 1'b0;
            checkOutput("dut2 seed load", 32'(lfsr2), 32'(seed2));
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            n = 0;
            while (!valid2 && n < 500) begin
                tick();
                n++;
            end
            checkOutput("dut2 draw completes", 32'(valid2), 1);
            checkOutput("dut2 busy clear", 32'(busy2), 0);
            seen = '0;
            bad = 1'b0;
            rep = 1'b0;
            for (int j = 0; j < 4; j++) begin
                dig = code2[j*3 +: 3];
                if (dig >= 3'd4) bad = 1'b1;
                if (seen[dig]) rep = 1'b1;
                seen[dig] = 1'b1;
            end
            checkOutput("dut2 digit range", 32'(bad), 0);
`ifdef LFSR_CODE_NO_REPEAT_EN
            checkOutput("dut2 permutation", 32'(seen), 'h0F);
`endif
            any_rep = any_rep | rep;
            ack2 = 1'b1;
            tick();
            ack2 = 1'b0;
        end
`ifndef LFSR_CODE_NO_REPEAT_EN
        checkOutput("dut2 repeats occur", 32'(any_rep), 1);
`endif

        tick();
        checkOutput("scoreboard drained", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
